// File: rtl/mdu_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package mdu_pkg;

    localparam int MDU_WIDTH   = 32;
    localparam int MDU_LATENCY = MDU_WIDTH + 1;

    typedef enum logic [2:0] {
        NONE  = 3'd0,
        MULT  = 3'd1,
        MULTU = 3'd2,
        DIV   = 3'd3,
        DIVU  = 3'd4,
        MTHI  = 3'd5,
        MTLO  = 3'd6
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mdu_state_t;

    function automatic logic is_md_op(mdu_op_t o);
        return (o == MULT) || (o == MULTU) || (o == DIV) || (o == DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration over the {upper, lower} accumulator: shift-add
// multiply (multiplier in the low half) or restoring divide (quotient in the low half).
module mdu_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [WIDTH-1:0]     operand,
    output logic [2*WIDTH-1:0]   acc_out
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted_rem;
    logic [WIDTH:0] trial;

    always_comb begin
        sum         = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
        shifted_rem = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
        trial       = shifted_rem - {1'b0, operand};
        acc_out     = {sum, acc_in[WIDTH-1:1]};
        if (is_div) begin
            // Remainder stays below the divisor, so trial's top bit is a pure borrow flag.
            if (trial[WIDTH]) begin
                acc_out = {shifted_rem[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
            end else begin
                acc_out = {trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; results land WIDTH+1 edges after accept.
// busy gates further issue; starts seen while busy are dropped.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH);

    mdu_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    mdu_op_t              op_q, op_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 dz_q, dz_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    mdu_op_t              op_in;
    logic                 is_div;
    logic                 signed_op;
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic [2*WIDTH-1:0]   step_out;
    logic [2*WIDTH-1:0]   prod;

    assign op_in     = mdu_op_t'(op);
    assign is_div    = (op_q == DIV) || (op_q == DIVU);
    assign signed_op = (op_in == MULT) || (op_in == DIV);
    assign a_neg     = signed_op & rs_data[WIDTH-1];
    assign b_neg     = signed_op & rt_data[WIDTH-1];
    assign a_mag     = a_neg ? -rs_data : rs_data;
    assign b_mag     = b_neg ? -rt_data : rt_data;
    assign prod      = neg_res_q ? -acc_q : acc_q;

    mdu_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .acc_in  (acc_q),
        .operand (opb_q),
        .acc_out (step_out)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && is_md_op(op_in)) begin
                    op_d      = op_in;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg && (op_in == DIV);
                    dz_d      = (rt_data == '0);
                    opb_d     = b_mag;
                    acc_d     = {{WIDTH{1'b0}}, a_mag};
                    cnt_d     = '0;
                    state_d   = RUN;
                end else if (start && op_in == MTHI) begin
                    hi_d = rs_data;
                end else if (start && op_in == MTLO) begin
                    lo_d = rs_data;
                end
            end
            RUN: begin
                acc_d = step_out;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (is_div) begin
                    // Divide-by-zero quotient is forced; the remainder path already yields rs.
                    lo_d = dz_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
                    hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= NONE;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            opb_q     <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model checked every cycle, plus pinned directed cases.
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] rs_data, rt_data;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    // Reference model: architectural result computed up front, released after the fixed latency.
    bit           check_en = 1'b0;
    bit           m_busy   = 1'b0;
    bit           m_done   = 1'b0;
    int           m_left   = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    task automatic ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] rh, output logic [31:0] rl);
        longint     sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        rh = '0;
        rl = '0;
        case (o)
            3'd1: begin p = 64'(sa * sb); rh = p[63:32]; rl = p[31:0]; end
            3'd2: begin p = {32'b0, a} * {32'b0, b}; rh = p[63:32]; rl = p[31:0]; end
            3'd3: begin
                if (b == 0) begin rl = '1; rh = a; end
                else begin q = sa / sb; r = sa % sb; rl = q[31:0]; rh = r[31:0]; end
            end
            3'd4: begin
                if (b == 0) begin rl = '1; rh = a; end
                else begin rl = a / b; rh = a % b; end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        m_done = 1'b0;
        if (reset) begin
            m_busy = 1'b0; m_left = 0; m_hi = '0; m_lo = '0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0; m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
            end
        end else if (start) begin
            if (op inside {3'd1, 3'd2, 3'd3, 3'd4}) begin
                ref_result(op, rs_data, rt_data, p_hi, p_lo);
                m_busy = 1'b1;
                m_left = MDU_LATENCY;
            end else if (op == 3'd5) begin
                m_hi = rs_data;
            end else if (op == 3'd6) begin
                m_lo = rs_data;
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            cmp("model_busy", 32'(busy), 32'(m_busy));
            cmp("model_done", 32'(done), 32'(m_done));
            cmp("model_hi", hi, m_hi);
            cmp("model_lo", lo, m_lo);
        end
    end

    // Called at a negedge; start is seen on the following posedge.
    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(negedge clk);
        start = 1'b0; op = 3'd0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        cmp("done_seen", 32'(done), 32'd1);
    endtask

    task automatic run_case(input string name, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        drive(o, a, b);
        cmp({name, "_busy"}, 32'(busy), 32'd1);
        @(negedge clk);
        wait_done(n);
        cmp({name, "_latency"}, n, 32'd33);
        cmp({name, "_hi"}, hi, eh);
        cmp({name, "_lo"}, lo, el);
        @(negedge clk);
        cmp({name, "_done_width"}, 32'(done), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, dones;
        reset = 1'b1; start = 1'b0; op = 3'd0; rs_data = '0; rt_data = '0;
        @(negedge clk);
        check_en = 1'b1;
        @(negedge clk);
        cmp("rst_busy", 32'(busy), 32'd0);
        cmp("rst_done", 32'(done), 32'd0);
        cmp("rst_hi", hi, 32'h0);
        cmp("rst_lo", lo, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        run_case("mult_neg", MULT, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_case("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
        run_case("div_neg7", DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_case("divu_zero", DIVU, 32'h7, 32'h0, 32'h7, 32'hFFFF_FFFF);
        run_case("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_case("div_zero_neg", DIV, 32'hFFFF_FFF0, 32'h0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

        // Starts while busy are dropped.
        drive(MULTU, 32'd5, 32'd6);
        repeat (9) @(negedge clk);
        drive(DIVU, 32'd9, 32'd3);
        drive(MTHI, 32'hDEAD_BEEF, 32'h0);
        wait_done(n);
        cmp("ignore_hi", hi, 32'h0);
        cmp("ignore_lo", lo, 32'd30);
        @(negedge clk);
        drive(MTHI, 32'h1234_5678, 32'h0);
        cmp("mthi_hi", hi, 32'h1234_5678);
        cmp("mthi_lo", lo, 32'd30);
        cmp("mthi_done", 32'(done), 32'd0);
        cmp("mthi_busy", 32'(busy), 32'd0);

        // Reset mid-divide aborts with no result and no done.
        drive(DIVU, 32'd100, 32'd7);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        cmp("abort_busy", 32'(busy), 32'd0);
        cmp("abort_hi", hi, 32'h0);
        cmp("abort_lo", lo, 32'h0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        cmp("abort_no_done", dones, 32'd0);
        run_case("divu_after", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        // Random traffic, including starts while busy, illegal codes and rare resets.
        for (int i = 0; i < 4000; i++) begin
            reset   = ($urandom_range(0, 499) == 0);
            start   = ($urandom_range(0, 3) == 0);
            op      = 3'($urandom_range(0, 7));
            rs_data = pick();
            rt_data = pick();
            @(negedge clk);
        end
        reset = 1'b0; start = 1'b0; op = 3'd0;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        cmp("drain_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
